smi_tx_ctrl: RTL and testbench
==============================

Name: smi_tx_ctrl

Overview:
- SMI write-direction controller: accepts bytes written by the RPi over SMI and packs each group of four into a 32-bit word.
- Pushes each completed word into the 0.9 GHz or 2.4 GHz TX FIFO, selected by SMI address.
- Counterpart of the SMI read path; sits between the SMI pads and the two TX FIFOs.
- Exposes status, sticky errors and a version byte through the standard ioc register interface.

Parameters:
- SYNC_STAGES, 2, flop stages for synchronising SWE, address and data into i_sys_clk.
- MODULE_VERSION, 8'h01, value returned at ioc 0.

Ports:
- i_sys_clk  in  1  system clock; only clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ioc  in  5  register select.
- i_data_in  in  8  register write data.
- o_data_out  out  8  register read data.
- i_cs  in  1  module select.
- i_fetch_cmd  in  1  register read strobe.
- i_load_cmd  in  1  register write strobe.
- i_smi_a  in  3  SMI address; 3'b100 targets the 0.9 GHz FIFO, 3'b101 the 2.4 GHz FIFO.
- i_smi_swe_srw  in  1  SMI write strobe, active-low; a byte completes on its rising edge.
- i_smi_data_in  in  8  SMI write data.
- o_smi_write_req  out  1  high when the currently addressed TX FIFO is not full.
- o_fifo_09_push  out  1  one-cycle push into the 0.9 GHz FIFO.
- o_fifo_09_push_data  out  32  word for the 0.9 GHz FIFO.
- i_fifo_09_full  in  1  0.9 GHz FIFO full.
- o_fifo_24_push  out  1  one-cycle push into the 2.4 GHz FIFO.
- o_fifo_24_push_data  out  32  word for the 2.4 GHz FIFO.
- i_fifo_24_full  in  1  2.4 GHz FIFO full.
- o_address_error  out  1  sticky; a write strobe arrived with an address other than 100 or 101.

Behaviour:
- Reset (async assert, sync release): all outputs 0; byte count 0; shift register 0; sticky flags 0; sync chains set to SWE=1.
- Synchronisation: SWE, address and data each pass through SYNC_STAGES flops. The edge detector registers the last synced SWE.
- Byte capture: a byte is captured when synced SWE goes 0->1. Latency is SYNC_STAGES+1 cycles from the pad edge. Address and data are sampled from the same synced stage.
- Packing is MSB first: the first byte goes to [31:24], the fourth to [7:0].
- State machine:
  - COLLECT (byte count 0..3) -> PUSH on the 4th valid byte.
  - PUSH lasts one cycle, then returns to COLLECT with count 0.
- PUSH cycle:
  - Drive push_data with the assembled word and pulse the selected push for exactly one cycle.
  - If that FIFO's full is high in the PUSH cycle: no push, word dropped, sticky overflow flag for that channel set.
- Channel change mid-word (address differs from the word's first byte while count is nonzero):
  - Partial word discarded and sticky framing error set.
  - The new byte starts a fresh word (count=1).
- Invalid address (not 100 or 101) on capture: byte ignored, count unchanged, o_address_error set.
- Strobe edge during the PUSH cycle: the byte is captured into the next word. The FSM must not lose it; minimum strobe spacing is 4 cycles, so it cannot collide with a second edge.
- Push outputs are never asserted for both channels in the same cycle.
- o_smi_write_req is combinational from the synced address: 100 -> !i_fifo_09_full; 101 -> !i_fifo_24_full; else 0.
- Register reads (i_cs and i_fetch_cmd; o_data_out registered, 1-cycle latency):
  - ioc 0: MODULE_VERSION.
  - ioc 1: bit0 09 full, bit1 24 full, bit2 09 overflow, bit3 24 overflow, bit4 framing error, bit5 partial word pending, bit6 address error, bit7 0.
- Register write (i_cs and i_load_cmd, ioc 2): write-1-to-clear bits 2,3,4,6 of the status byte. If the same cycle also sets a flag, set wins.

Decomposition:
- Shared package holds:
  - ioc codes (version 0, status 1, clear 2)
  - SMI address constants 3'b100 and 3'b101
  - status bit indices
- Natural sub-module: smi_sync_edge (SYNC_STAGES synchroniser plus rising-edge detect), reusable by the read path.

Test Plan:
- Four strobes at a=100 with bytes DE, AD, BE, EF -> single o_fifo_09_push, data 32'hDEADBEEF; o_fifo_24_push stays 0.
- 09 FIFO full, four bytes at a=100 -> no push; ioc 1 read returns bit2=1; ioc 2 write 8'h04 clears it.
- Two bytes at a=100, then four bytes 11, 22, 33, 44 at a=101 -> no 09 push; one 24 push of 32'h11223344; framing bit4=1.
- Strobe at a=011 -> o_address_error=1; byte count unchanged; next four a=100 bytes pack correctly.
- Reset asserted after 3 bytes -> all outputs 0 immediately; after release, 4 new bytes yield one correct word.
- a=101 with i_fifo_24_full=1 -> o_smi_write_req=0; switch to a=100 with 09 not full -> 1 after SYNC_STAGES cycles.

Source files
------------

// File: rtl/smi_tx_ctrl_pkg.sv
// Shared definitions for the SMI write-direction controller.
// Holds the ioc register codes, the SMI addresses of the two TX FIFOs,
// the status byte bit positions and the controller's enum types.
package smi_tx_ctrl_pkg;

  localparam logic [4:0] IOC_VERSION = 5'd0;
  localparam logic [4:0] IOC_STATUS  = 5'd1;
  localparam logic [4:0] IOC_CLEAR   = 5'd2;

  localparam logic [2:0] SMI_ADDR_09 = 3'b100;
  localparam logic [2:0] SMI_ADDR_24 = 3'b101;

  localparam int ST_FULL_09   = 0;
  localparam int ST_FULL_24   = 1;
  localparam int ST_OVF_09    = 2;
  localparam int ST_OVF_24    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_PENDING   = 5;
  localparam int ST_ADDR_ERR  = 6;

  // Status bits that are sticky and write-1-to-clear.
  localparam logic [7:0] STICKY_MASK = 8'h5C;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PUSH    = 1'b1
  } tx_state_t;

  typedef enum logic {
    CH_09 = 1'b0,
    CH_24 = 1'b1
  } tx_chan_t;

endpackage

// File: rtl/smi_sync_edge.sv
// Synchroniser for an asynchronous SMI strobe plus its qualifying bus,
// with rising-edge detection on the synchronised strobe.
// Ports:
//   i_sys_clk, i_reset_n : system clock, async active-low reset
//   async_strobe         : pad strobe (idles high)
//   async_data           : pad bus sampled alongside the strobe
//   data_sync            : bus after SYNC_STAGES flops
//   strobe_rise          : one-cycle pulse on a synced 0->1 strobe edge;
//                          data_sync is valid in the same cycle
module smi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 11
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              async_strobe,
  input  logic [DATA_W-1:0] async_data,
  output logic [DATA_W-1:0] data_sync,
  output logic              strobe_rise
);

  logic [SYNC_STAGES-1:0] strobe_chain;
  logic [DATA_W-1:0]      data_chain [SYNC_STAGES];
  logic                   strobe_last;
  logic                   strobe_sync;

  // Chains reset to an idle (high) strobe so release never fakes an edge.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      strobe_chain <= '1;
      strobe_last  <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_chain[i] <= '0;
    end else begin
      strobe_chain[0] <= async_strobe;
      data_chain[0]   <= async_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strobe_chain[i] <= strobe_chain[i-1];
        data_chain[i]   <= data_chain[i-1];
      end
      strobe_last <= strobe_chain[SYNC_STAGES-1];
    end
  end

  assign strobe_sync = strobe_chain[SYNC_STAGES-1];
  assign data_sync   = data_chain[SYNC_STAGES-1];
  assign strobe_rise = strobe_sync & ~strobe_last;

endmodule

// File: rtl/smi_tx_ctrl.sv
// SMI write-direction controller. Packs four SMI bytes (MSB first) into a
// 32-bit word and pushes it into the 0.9 GHz or 2.4 GHz TX FIFO chosen by
// the SMI address of the word's first byte.
// Ports:
//   i_sys_clk, i_reset_n                 : clock, async active-low reset
//   i_ioc, i_data_in, o_data_out         : ioc register select/write/read data
//   i_cs, i_fetch_cmd, i_load_cmd        : module select, read and write strobes
//   i_smi_a, i_smi_swe_srw, i_smi_data_in: SMI pads (address, write strobe, data)
//   o_smi_write_req                      : addressed TX FIFO can accept data
//   o_fifo_09_push/_push_data, i_fifo_09_full : 0.9 GHz FIFO interface
//   o_fifo_24_push/_push_data, i_fifo_24_full : 2.4 GHz FIFO interface
//   o_address_error                      : sticky invalid-address flag
module smi_tx_ctrl
  import smi_tx_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] MODULE_VERSION = 8'h01
) (
  input  logic        i_sys_clk,
  input  logic        i_reset_n,
  input  logic [4:0]  i_ioc,
  input  logic [7:0]  i_data_in,
  output logic [7:0]  o_data_out,
  input  logic        i_cs,
  input  logic        i_fetch_cmd,
  input  logic        i_load_cmd,
  input  logic [2:0]  i_smi_a,
  input  logic        i_smi_swe_srw,
  input  logic [7:0]  i_smi_data_in,
  output logic        o_smi_write_req,
  output logic        o_fifo_09_push,
  output logic [31:0] o_fifo_09_push_data,
  input  logic        i_fifo_09_full,
  output logic        o_fifo_24_push,
  output logic [31:0] o_fifo_24_push_data,
  input  logic        i_fifo_24_full,
  output logic        o_address_error
);

  logic [10:0] smi_bus_sync;
  logic [2:0]  smi_addr_sync;
  logic [7:0]  smi_byte_sync;
  logic        byte_rise;
  logic        addr_ok;
  tx_chan_t    byte_ch;

  tx_state_t   state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] shift_reg, shift_nxt;
  tx_chan_t    word_ch, word_ch_nxt;
  logic [7:0]  sticky, sticky_set, sticky_clr;
  logic [7:0]  status;

  // Pad to i_sys_clk boundary
  smi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .DATA_W      (11)
  ) u_sync (
    .i_sys_clk    (i_sys_clk),
    .i_reset_n    (i_reset_n),
    .async_strobe (i_smi_swe_srw),
    .async_data   ({i_smi_a, i_smi_data_in}),
    .data_sync    (smi_bus_sync),
    .strobe_rise  (byte_rise)
  );

  assign smi_addr_sync = smi_bus_sync[10:8];
  assign smi_byte_sync = smi_bus_sync[7:0];
  assign addr_ok = (smi_addr_sync == SMI_ADDR_09) || (smi_addr_sync == SMI_ADDR_24);
  assign byte_ch = (smi_addr_sync == SMI_ADDR_24) ? CH_24 : CH_09;

  always_comb begin
    case (smi_addr_sync)
      SMI_ADDR_09: o_smi_write_req = ~i_fifo_09_full;
      SMI_ADDR_24: o_smi_write_req = ~i_fifo_24_full;
      default:     o_smi_write_req = 1'b0;
    endcase
  end

  // Packing FSM: next state, word assembly, push outputs, flag sets
  always_comb begin
    state_nxt           = state;
    byte_cnt_nxt        = byte_cnt;
    shift_nxt           = shift_reg;
    word_ch_nxt         = word_ch;
    sticky_set          = 8'h00;
    o_fifo_09_push      = 1'b0;
    o_fifo_24_push      = 1'b0;
    o_fifo_09_push_data = 32'h0;
    o_fifo_24_push_data = 32'h0;

    if (state == ST_PUSH) begin
      state_nxt    = ST_COLLECT;
      byte_cnt_nxt = 2'd0;
      if (word_ch == CH_09) begin
        if (i_fifo_09_full) begin
          sticky_set[ST_OVF_09] = 1'b1;
        end else begin
          o_fifo_09_push      = 1'b1;
          o_fifo_09_push_data = shift_reg;
        end
      end else begin
        if (i_fifo_24_full) begin
          sticky_set[ST_OVF_24] = 1'b1;
        end else begin
          o_fifo_24_push      = 1'b1;
          o_fifo_24_push_data = shift_reg;
        end
      end
    end

    if (byte_rise) begin
      if (!addr_ok) begin
        sticky_set[ST_ADDR_ERR] = 1'b1;
      end else if (state == ST_PUSH) begin
        // The word being pushed is already in shift_reg this cycle, so the
        // new byte can safely start the next word.
        shift_nxt    = {24'h0, smi_byte_sync};
        byte_cnt_nxt = 2'd1;
        word_ch_nxt  = byte_ch;
      end else if ((byte_cnt != 2'd0) && (byte_ch != word_ch)) begin
        sticky_set[ST_FRAME_ERR] = 1'b1;
        shift_nxt    = {24'h0, smi_byte_sync};
        byte_cnt_nxt = 2'd1;
        word_ch_nxt  = byte_ch;
      end else begin
        shift_nxt = {shift_reg[23:0], smi_byte_sync};
        if (byte_cnt == 2'd0) word_ch_nxt = byte_ch;
        if (byte_cnt == 2'd3) begin
          state_nxt    = ST_PUSH;
          byte_cnt_nxt = 2'd0;
        end else begin
          byte_cnt_nxt = byte_cnt + 2'd1;
        end
      end
    end
  end

  assign sticky_clr = (i_cs && i_load_cmd && (i_ioc == IOC_CLEAR)) ? i_data_in : 8'h00;

  assign status = (sticky & STICKY_MASK)
                | {2'b00, (byte_cnt != 2'd0), 3'b000, i_fifo_24_full, i_fifo_09_full};

  assign o_address_error = sticky[ST_ADDR_ERR];

  // Registered state, word and register interface
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_COLLECT;
      byte_cnt   <= 2'd0;
      shift_reg  <= 32'h0;
      word_ch    <= CH_09;
      sticky     <= 8'h00;
      o_data_out <= 8'h00;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      shift_reg <= shift_nxt;
      word_ch   <= word_ch_nxt;
      // A flag raised in the same cycle as its clear stays set.
      sticky    <= (sticky_set | (sticky & ~sticky_clr)) & STICKY_MASK;
      if (i_cs && i_fetch_cmd) begin
        case (i_ioc)
          IOC_VERSION: o_data_out <= MODULE_VERSION;
          IOC_STATUS:  o_data_out <= status;
          default:     o_data_out <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smi_tx_ctrl.sv
module tb_smi_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  ioc = 5'd0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        cs = 1'b0, fetch_cmd = 1'b0, load_cmd = 1'b0;
  logic [2:0]  smi_a = 3'b000;
  logic        smi_swe = 1'b1;
  logic [7:0]  smi_d = 8'h00;
  logic        write_req;
  logic        push09, push24;
  logic [31:0] pdata09, pdata24;
  logic        full09 = 1'b0, full24 = 1'b0;
  logic        addr_err;

  int total = 0;
  int bad   = 0;
  int nboth = 0;
  logic [31:0] q09[$];
  logic [31:0] q24[$];

  always #5 clk = ~clk;

  smi_tx_ctrl #(.SYNC_STAGES(2), .MODULE_VERSION(8'h01)) dut (
    .i_sys_clk           (clk),
    .i_reset_n           (reset_n),
    .i_ioc               (ioc),
    .i_data_in           (data_in),
    .o_data_out          (data_out),
    .i_cs                (cs),
    .i_fetch_cmd         (fetch_cmd),
    .i_load_cmd          (load_cmd),
    .i_smi_a             (smi_a),
    .i_smi_swe_srw       (smi_swe),
    .i_smi_data_in       (smi_d),
    .o_smi_write_req     (write_req),
    .o_fifo_09_push      (push09),
    .o_fifo_09_push_data (pdata09),
    .i_fifo_09_full      (full09),
    .o_fifo_24_push      (push24),
    .o_fifo_24_push_data (pdata24),
    .i_fifo_24_full      (full24),
    .o_address_error     (addr_err)
  );

  always @(negedge clk) begin
    if (push09) q09.push_back(pdata09);
    if (push24) q24.push_back(pdata24);
    if (push09 && push24) nboth++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic smi_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    smi_a = a; smi_d = d; smi_swe = 1'b0;
    tick(3);
    smi_swe = 1'b1;
    tick(5);
  endtask

  // Minimum strobe spacing: 2 cycles low, 2 cycles high.
  task automatic smi_write_fast(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    smi_a = a; smi_d = d; smi_swe = 1'b0;
    tick(2);
    smi_swe = 1'b1;
    tick(1);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [7:0] v);
    @(negedge clk);
    ioc = r; cs = 1'b1; fetch_cmd = 1'b1;
    @(negedge clk);
    v = data_out; cs = 1'b0; fetch_cmd = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [7:0] d);
    @(negedge clk);
    ioc = r; data_in = d; cs = 1'b1; load_cmd = 1'b1;
    @(negedge clk);
    cs = 1'b0; load_cmd = 1'b0; data_in = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [80:0] outs;
    tick(3);
    outs = {push09, push24, write_req, addr_err, data_out, pdata09, pdata24};
    total++;
    if (outs !== 81'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", outs);
    end
    @(negedge clk); reset_n = 1'b1;
    tick(2);
    read_reg(5'd0, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL version got=%h want=01", v); end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", v); end
  endtask

  task automatic test_basic_pack();
    int s09, s24;
    logic [7:0] v;
    s09 = q09.size(); s24 = q24.size();
    smi_write(3'b100, 8'hDE);
    smi_write(3'b100, 8'hAD);
    smi_write(3'b100, 8'hBE);
    @(negedge clk);
    smi_a = 3'b100; smi_d = 8'hEF; smi_swe = 1'b0;
    tick(3);
    smi_swe = 1'b1;
    tick(2);
    total++;
    if (push09 !== 1'b0) begin bad++; $display("FAIL push_early got=%b want=0", push09); end
    tick(1);
    total++;
    if (push09 !== 1'b1 || pdata09 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL push_latency got push=%b data=%h want push=1 data=deadbeef", push09, pdata09);
    end
    tick(3);
    total++;
    if (q09.size() - s09 != 1 || q24.size() != s24) begin
      bad++; $display("FAIL basic_push_count got 09=%0d 24=%0d want 09=1 24=0", q09.size() - s09, q24.size() - s24);
    end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL basic_status got=%h want=00", v); end
  endtask

  task automatic test_overflow();
    int s09;
    logic [7:0] v;
    s09 = q09.size();
    full09 = 1'b1;
    smi_write(3'b100, 8'h01);
    smi_write(3'b100, 8'h02);
    smi_write(3'b100, 8'h03);
    smi_write(3'b100, 8'h04);
    total++;
    if (write_req !== 1'b0) begin bad++; $display("FAIL ovf_write_req got=%b want=0", write_req); end
    total++;
    if (q09.size() != s09) begin bad++; $display("FAIL ovf_no_push got=%0d want=0", q09.size() - s09); end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h05) begin bad++; $display("FAIL ovf_status got=%h want=05", v); end
    write_reg(5'd2, 8'h04);
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL ovf_clear got=%h want=01", v); end
    full09 = 1'b0;
    tick(1);
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h00 || write_req !== 1'b1) begin
      bad++; $display("FAIL ovf_release got status=%h req=%b want status=00 req=1", v, write_req);
    end
  endtask

  task automatic test_framing();
    int s09, s24;
    logic [7:0] v;
    s09 = q09.size(); s24 = q24.size();
    smi_write(3'b100, 8'hAA);
    smi_write(3'b100, 8'hBB);
    smi_write(3'b101, 8'h11);
    smi_write(3'b101, 8'h22);
    smi_write(3'b101, 8'h33);
    smi_write(3'b101, 8'h44);
    total++;
    if (q09.size() != s09 || q24.size() - s24 != 1) begin
      bad++; $display("FAIL frame_push_count got 09=%0d 24=%0d want 09=0 24=1", q09.size() - s09, q24.size() - s24);
    end else begin
      total++;
      if (q24[q24.size()-1] !== 32'h11223344) begin
        bad++; $display("FAIL frame_word got=%h want=11223344", q24[q24.size()-1]);
      end
    end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h10) begin bad++; $display("FAIL frame_status got=%h want=10", v); end
    write_reg(5'd2, 8'h10);
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL frame_clear got=%h want=00", v); end
  endtask

  task automatic test_addr_error();
    int s09;
    logic [7:0] v;
    s09 = q09.size();
    smi_write(3'b100, 8'h01);
    smi_write(3'b011, 8'hFF);
    total++;
    if (addr_err !== 1'b1) begin bad++; $display("FAIL addr_err_flag got=%b want=1", addr_err); end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h60) begin bad++; $display("FAIL addr_err_status got=%h want=60", v); end
    smi_write(3'b100, 8'h02);
    smi_write(3'b100, 8'h03);
    smi_write(3'b100, 8'h04);
    total++;
    if (q09.size() - s09 != 1) begin
      bad++; $display("FAIL addr_err_push_count got=%0d want=1", q09.size() - s09);
    end else begin
      total++;
      if (q09[q09.size()-1] !== 32'h01020304) begin
        bad++; $display("FAIL addr_err_word got=%h want=01020304", q09[q09.size()-1]);
      end
    end
    write_reg(5'd2, 8'h40);
    tick(1);
    total++;
    if (addr_err !== 1'b0) begin bad++; $display("FAIL addr_err_clear got=%b want=0", addr_err); end
  endtask

  task automatic test_write_req();
    full24 = 1'b1;
    @(negedge clk); smi_a = 3'b101;
    tick(3);
    total++;
    if (write_req !== 1'b0) begin bad++; $display("FAIL req_24_full got=%b want=0", write_req); end
    @(negedge clk); smi_a = 3'b100;
    @(negedge clk);
    total++;
    if (write_req !== 1'b0) begin bad++; $display("FAIL req_sync_early got=%b want=0", write_req); end
    @(negedge clk);
    total++;
    if (write_req !== 1'b1) begin bad++; $display("FAIL req_09_ready got=%b want=1", write_req); end
    full24 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s09;
    s09 = q09.size();
    smi_write_fast(3'b100, 8'h10);
    smi_write_fast(3'b100, 8'h20);
    smi_write_fast(3'b100, 8'h30);
    smi_write_fast(3'b100, 8'h40);
    smi_write_fast(3'b100, 8'h50);
    smi_write_fast(3'b100, 8'h60);
    smi_write_fast(3'b100, 8'h70);
    smi_write_fast(3'b100, 8'h80);
    tick(6);
    total++;
    if (q09.size() - s09 != 2) begin
      bad++; $display("FAIL b2b_push_count got=%0d want=2", q09.size() - s09);
    end else begin
      total++;
      if (q09[s09] !== 32'h10203040 || q09[s09+1] !== 32'h50607080) begin
        bad++; $display("FAIL b2b_words got=%h,%h want=10203040,50607080", q09[s09], q09[s09+1]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int s09;
    logic [7:0] v;
    logic [80:0] outs;
    s09 = q09.size();
    smi_write(3'b100, 8'h11);
    smi_write(3'b100, 8'h22);
    smi_write(3'b100, 8'h33);
    smi_write(3'b010, 8'h00);
    read_reg(5'd0, v);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    outs = {push09, push24, write_req, addr_err, data_out, pdata09, pdata24};
    total++;
    if (outs !== 81'h0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", outs); end
    @(negedge clk); reset_n = 1'b1;
    tick(2);
    smi_write(3'b100, 8'hCA);
    smi_write(3'b100, 8'hFE);
    smi_write(3'b100, 8'hF0);
    smi_write(3'b100, 8'h0D);
    total++;
    if (q09.size() - s09 != 1) begin
      bad++; $display("FAIL midreset_push_count got=%0d want=1", q09.size() - s09);
    end else begin
      total++;
      if (q09[q09.size()-1] !== 32'hCAFEF00D) begin
        bad++; $display("FAIL midreset_word got=%h want=cafef00d", q09[q09.size()-1]);
      end
    end
    read_reg(5'd1, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL midreset_status got=%h want=00", v); end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_overflow();
    test_framing();
    test_addr_error();
    test_write_req();
    test_back_to_back();
    test_reset_mid_word();
    total++;
    if (nboth != 0) begin bad++; $display("FAIL dual_push got=%0d want=0", nboth); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
